// File: rtl/mosfet_sequence_decoder.sv
// mosfet_sequence_decoder: debounces the 4-bit MOSFET command word and tracks it
// with an FSM that rebuilds sigma and the automaton counter, and flags faults.
// Ports:
//   i_clock, i_RESET (sync, active-high), i_MOSFET[3:0] {M3..M0}, i_clear
//   o_sigma[1:0], o_counter[1:0], o_period[31:0], o_period_valid
//   o_fault, o_fault_code[1:0], o_stall, o_gate_enable
module mosfet_sequence_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [31:0] TIMEOUT       = 32'd100000
) (
  input  logic        i_clock,
  input  logic        i_RESET,
  input  logic [3:0]  i_MOSFET,
  input  logic        i_clear,
  output logic [1:0]  o_sigma,
  output logic [1:0]  o_counter,
  output logic [31:0] o_period,
  output logic        o_period_valid,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic        o_stall,
  output logic        o_gate_enable
);

  localparam int HW = $clog2(STABLE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(STABLE_CYCLES);

  localparam logic [3:0] C_POS  = 4'b1001;
  localparam logic [3:0] C_ZERO = 4'b0011;
  localparam logic [3:0] C_NEG  = 4'b0110;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_SHOOT   = 2'b10;
  localparam logic [1:0] F_SEQ     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_POS, S_ZP, S_NEG, S_ZN, S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    SYM_BAD, SYM_POS, SYM_ZERO, SYM_NEG
  } sym_t;

  // Debounce and last-accepted code
  logic [3:0]    mos_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    acc_q, acc_d;
  logic          accept;
  sym_t          sym;

  // FSM
  state_t        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic          shoot, bad_code, bad_seq;

  // Registered outputs
  logic [1:0]    sigma_q, sigma_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          gate_q, gate_d;

  // Period / stall measurement
  logic [31:0]   pcnt_q, pcnt_d;
  logic [31:0]   period_q, period_d;
  logic          pvalid_q, pvalid_d;
  logic          seen_q, seen_d;
  logic          pos_entry;
  logic [31:0]   stall_q, stall_d;

  // The hold counter restarts at 1 on the edge that loads a new word,
  // so it reads STABLE_CYCLES after that many cycles of stability.
  always_comb begin
    hold_d = hold_q;
    if (i_MOSFET != mos_q) begin
      hold_d = HW'(1);
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HW'(1);
    end
  end

  assign accept = (hold_q == HOLD_MAX) && (mos_q != acc_q);
  assign acc_d  = accept ? mos_q : acc_q;

  always_comb begin
    sym = SYM_BAD;
    unique case (1'b1)
      (mos_q == C_POS):  sym = SYM_POS;
      (mos_q == C_ZERO): sym = SYM_ZERO;
      (mos_q == C_NEG):  sym = SYM_NEG;
      default:           sym = SYM_BAD;
    endcase
  end

  // Shoot-through looks at the raw word: it must not wait for debounce.
  assign shoot = (i_MOSFET[0] & i_MOSFET[2])
               | (i_MOSFET[1] & i_MOSFET[3]);

  assign bad_code = accept && (sym == SYM_BAD);

  assign bad_seq = accept
                && (((state_q == S_ZP) && (sym == SYM_POS))
                 || ((state_q == S_ZN) && (sym == SYM_NEG)));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (state_q == S_FAULT) begin
      // A fresh fault beats a simultaneous clear; the first code is kept.
      if (i_clear && !shoot && !bad_code) begin
        state_d = S_IDLE;
        code_d  = F_NONE;
      end
    end else if (shoot) begin
      state_d = S_FAULT;
      code_d  = F_SHOOT;
    end else if (bad_code) begin
      state_d = S_FAULT;
      code_d  = F_ILLEGAL;
    end else if (bad_seq) begin
      state_d = S_FAULT;
      code_d  = F_SEQ;
    end else if (i_clear) begin
      state_d = S_IDLE;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (sym == SYM_POS) state_d = S_POS;
          else if (sym == SYM_NEG) state_d = S_NEG;
        end
        S_POS: begin
          if (sym == SYM_ZERO) state_d = S_ZP;
          else if (sym == SYM_NEG) state_d = S_NEG;
        end
        S_ZP: begin
          if (sym == SYM_NEG) state_d = S_NEG;
        end
        S_NEG: begin
          if (sym == SYM_ZERO) state_d = S_ZN;
          else if (sym == SYM_POS) state_d = S_POS;
        end
        S_ZN: begin
          if (sym == SYM_POS) state_d = S_POS;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the
  // same edge as the state register.
  always_comb begin
    sigma_d = 2'b00;
    cnt_d   = 2'b00;
    gate_d  = 1'b1;
    unique case (state_d)
      S_POS: begin sigma_d = 2'b01; cnt_d = 2'b00; end
      S_ZP:  begin sigma_d = 2'b00; cnt_d = 2'b01; end
      S_NEG: begin sigma_d = 2'b11; cnt_d = 2'b10; end
      S_ZN:  begin sigma_d = 2'b00; cnt_d = 2'b11; end
      default: gate_d = 1'b0;
    endcase
  end

  assign pos_entry = (state_d == S_POS) && (state_q != S_POS);

  // The first +1 entry after idle has no previous reference point, so
  // it only restarts the count.
  always_comb begin
    pcnt_d   = (pcnt_q == '1) ? pcnt_q : pcnt_q + 32'd1;
    period_d = period_q;
    pvalid_d = 1'b0;
    seen_d   = seen_q;
    if (pos_entry) begin
      pcnt_d = 32'd1;
      seen_d = 1'b1;
      if (seen_q) begin
        period_d = pcnt_q;
        pvalid_d = 1'b1;
      end
    end
    if ((state_d == S_IDLE) || (state_d == S_FAULT)) begin
      seen_d = 1'b0;
    end
  end

  always_comb begin
    stall_d = (stall_q == '1) ? stall_q : stall_q + 32'd1;
    if (accept) begin
      stall_d = 32'd0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      mos_q    <= 4'b0000;
      hold_q   <= '0;
      acc_q    <= 4'b0000;
      state_q  <= S_IDLE;
      code_q   <= F_NONE;
      sigma_q  <= 2'b00;
      cnt_q    <= 2'b00;
      gate_q   <= 1'b0;
      pcnt_q   <= 32'd0;
      period_q <= 32'd0;
      pvalid_q <= 1'b0;
      seen_q   <= 1'b0;
      stall_q  <= 32'd0;
    end else begin
      mos_q    <= i_MOSFET;
      hold_q   <= hold_d;
      acc_q    <= acc_d;
      state_q  <= state_d;
      code_q   <= code_d;
      sigma_q  <= sigma_d;
      cnt_q    <= cnt_d;
      gate_q   <= gate_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      seen_q   <= seen_d;
      stall_q  <= stall_d;
    end
  end

  assign o_sigma        = sigma_q;
  assign o_counter      = cnt_q;
  assign o_period       = period_q;
  assign o_period_valid = pvalid_q;
  assign o_fault        = (state_q == S_FAULT);
  assign o_fault_code   = code_q;
  assign o_stall        = (stall_q >= TIMEOUT);
  assign o_gate_enable  = gate_q;

endmodule

// File: tb/tb_mosfet_sequence_decoder.sv
// tb_mosfet_sequence_decoder: directed scenarios for the MOSFET decoder
// with hand-computed expectations (STABLE_CYCLES=4, TIMEOUT=1000).
module tb_mosfet_sequence_decoder;

  logic        i_clock = 1'b0;
  logic        i_RESET;
  logic [3:0]  i_MOSFET;
  logic        i_clear;
  logic [1:0]  o_sigma;
  logic [1:0]  o_counter;
  logic [31:0] o_period;
  logic        o_period_valid;
  logic        o_fault;
  logic [1:0]  o_fault_code;
  logic        o_stall;
  logic        o_gate_enable;

  int vecs = 0;
  int errs = 0;

  always #5 i_clock = ~i_clock;

  mosfet_sequence_decoder #(
    .STABLE_CYCLES(4),
    .TIMEOUT(32'd1000)
  ) dut (
    .i_clock(i_clock),
    .i_RESET(i_RESET),
    .i_MOSFET(i_MOSFET),
    .i_clear(i_clear),
    .o_sigma(o_sigma),
    .o_counter(o_counter),
    .o_period(o_period),
    .o_period_valid(o_period_valid),
    .o_fault(o_fault),
    .o_fault_code(o_fault_code),
    .o_stall(o_stall),
    .o_gate_enable(o_gate_enable)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic do_reset;
    i_RESET  = 1'b1;
    i_MOSFET = 4'b0000;
    i_clear  = 1'b0;
    step(2);
    i_RESET  = 1'b0;
  endtask

  function automatic logic [3:0] t1_code(input int i);
    return (i == 0) ? 4'b1001 : (i == 2) ? 4'b0110 : 4'b0011;
  endfunction

  function automatic logic [1:0] t1_sig(input int i);
    return (i == 0) ? 2'b01 : (i == 2) ? 2'b11 : 2'b00;
  endfunction

  task automatic test_reset;
    i_RESET  = 1'b1;
    i_MOSFET = 4'b0000;
    i_clear  = 1'b0;
    step(2);
    vecs++;
    if ({o_sigma, o_counter, o_fault_code} !== 6'b0) begin
      errs++;
      $display("FAIL rst_sig_cnt_code: got %b want 000000",
               {o_sigma, o_counter, o_fault_code});
    end
    vecs++;
    if ({o_period_valid, o_fault, o_stall, o_gate_enable} !== 4'b0) begin
      errs++;
      $display("FAIL rst_flags: got %b want 0000",
               {o_period_valid, o_fault, o_stall, o_gate_enable});
    end
    vecs++;
    if (o_period !== 32'd0) begin
      errs++;
      $display("FAIL rst_period: got %0d want 0", o_period);
    end
    i_RESET = 1'b0;
  endtask

  task automatic test_four_step;
    logic [1:0] prev;
    do_reset;
    prev = 2'b00;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        i_MOSFET = t1_code(i);
        step(4);
        vecs++;
        if (o_sigma !== prev) begin
          errs++;
          $display("FAIL t1_latency r%0d i%0d: got %b want %b",
                   r, i, o_sigma, prev);
        end
        step(1);
        vecs++;
        if ({o_sigma, o_counter} !== {t1_sig(i), 2'(i)}) begin
          errs++;
          $display("FAIL t1_state r%0d i%0d: got %b want %b",
                   r, i, {o_sigma, o_counter}, {t1_sig(i), 2'(i)});
        end
        vecs++;
        if ({o_fault, o_gate_enable} !== 2'b01) begin
          errs++;
          $display("FAIL t1_flags r%0d i%0d: got %b want 01",
                   r, i, {o_fault, o_gate_enable});
        end
        if (i == 0) begin
          vecs++;
          if (o_period_valid !== (r != 0)) begin
            errs++;
            $display("FAIL t1_pvalid r%0d: got %b want %b",
                     r, o_period_valid, (r != 0));
          end
          vecs++;
          if (o_period !== ((r != 0) ? 32'd200 : 32'd0)) begin
            errs++;
            $display("FAIL t1_period r%0d: got %0d want %0d",
                     r, o_period, (r != 0) ? 200 : 0);
          end
        end
        prev = t1_sig(i);
        step(45);
      end
    end
  endtask

  task automatic test_two_step;
    logic [1:0] es;
    do_reset;
    for (int k = 0; k < 6; k++) begin
      i_MOSFET = (k % 2 == 0) ? 4'b1001 : 4'b0110;
      es = (k % 2 == 0) ? 2'b01 : 2'b11;
      step(5);
      vecs++;
      if ({o_sigma, o_fault} !== {es, 1'b0}) begin
        errs++;
        $display("FAIL t2_sigma k%0d: got %b want %b",
                 k, {o_sigma, o_fault}, {es, 1'b0});
      end
      if (k % 2 == 0) begin
        vecs++;
        if ({o_period_valid, o_period} !==
            {(k != 0), ((k != 0) ? 32'd60 : 32'd0)}) begin
          errs++;
          $display("FAIL t2_period k%0d: got %b/%0d", k,
                   o_period_valid, o_period);
        end
      end
      step(25);
    end
  endtask

  task automatic test_debounce;
    do_reset;
    i_MOSFET = 4'b1001;
    step(20);
    i_MOSFET = 4'b0110;
    step(2);
    i_MOSFET = 4'b1001;
    for (int c = 0; c < 20; c++) begin
      step(1);
      vecs++;
      if ({o_sigma, o_fault} !== 3'b010) begin
        errs++;
        $display("FAIL t3_glitch c%0d: got %b want 010",
                 c, {o_sigma, o_fault});
      end
    end
  endtask

  task automatic test_shoot_through;
    i_MOSFET = 4'b1111;
    step(1);
    vecs++;
    if ({o_fault, o_fault_code, o_gate_enable, o_sigma} !== 6'b110000) begin
      errs++;
      $display("FAIL t4_shoot: got %b want 110000",
               {o_fault, o_fault_code, o_gate_enable, o_sigma});
    end
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
    vecs++;
    if ({o_fault, o_fault_code} !== 3'b110) begin
      errs++;
      $display("FAIL t4_clear_vs_fault: got %b want 110",
               {o_fault, o_fault_code});
    end
    i_MOSFET = 4'b1001;
    step(3);
    vecs++;
    if (o_fault !== 1'b1) begin
      errs++;
      $display("FAIL t4_sticky: got %b want 1", o_fault);
    end
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
    vecs++;
    if ({o_fault, o_fault_code, o_gate_enable} !== 4'b0000) begin
      errs++;
      $display("FAIL t4_cleared: got %b want 0000",
               {o_fault, o_fault_code, o_gate_enable});
    end
    step(10);
    vecs++;
    if ({o_sigma, o_gate_enable} !== 3'b000) begin
      errs++;
      $display("FAIL t4_idle: got %b want 000",
               {o_sigma, o_gate_enable});
    end
  endtask

  task automatic test_sequence_faults;
    do_reset;
    i_MOSFET = 4'b1001;
    step(20);
    i_MOSFET = 4'b0011;
    step(20);
    i_MOSFET = 4'b1001;
    step(4);
    vecs++;
    if ({o_counter, o_fault} !== 3'b010) begin
      errs++;
      $display("FAIL t5_zp: got %b want 010", {o_counter, o_fault});
    end
    step(1);
    vecs++;
    if ({o_fault, o_fault_code} !== 3'b111) begin
      errs++;
      $display("FAIL t5_badseq_zp: got %b want 111",
               {o_fault, o_fault_code});
    end
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
    vecs++;
    if ({o_fault, o_fault_code} !== 3'b000) begin
      errs++;
      $display("FAIL t5_clear: got %b want 000",
               {o_fault, o_fault_code});
    end
    i_MOSFET = 4'b0000;
    step(4);
    vecs++;
    if (o_fault !== 1'b0) begin
      errs++;
      $display("FAIL t5_illegal_early: got %b want 0", o_fault);
    end
    step(1);
    vecs++;
    if ({o_fault, o_fault_code} !== 3'b101) begin
      errs++;
      $display("FAIL t5_illegal: got %b want 101",
               {o_fault, o_fault_code});
    end
    i_RESET = 1'b1;
    step(1);
    i_RESET = 1'b0;
    vecs++;
    if ({o_fault, o_fault_code, o_gate_enable} !== 4'b0000) begin
      errs++;
      $display("FAIL t5_reset_in_fault: got %b want 0000",
               {o_fault, o_fault_code, o_gate_enable});
    end
    do_reset;
    i_MOSFET = 4'b0110;
    step(20);
    i_MOSFET = 4'b0011;
    step(20);
    vecs++;
    if ({o_sigma, o_counter} !== 4'b0011) begin
      errs++;
      $display("FAIL t5_zn: got %b want 0011", {o_sigma, o_counter});
    end
    i_MOSFET = 4'b0110;
    step(5);
    vecs++;
    if ({o_fault, o_fault_code} !== 3'b111) begin
      errs++;
      $display("FAIL t5_badseq_zn: got %b want 111",
               {o_fault, o_fault_code});
    end
  endtask

  task automatic test_stall_and_reset;
    do_reset;
    i_MOSFET = 4'b1001;
    step(30);
    i_MOSFET = 4'b0110;
    step(30);
    i_MOSFET = 4'b1001;
    step(5);
    vecs++;
    if ({o_period_valid, o_period} !== {1'b1, 32'd60}) begin
      errs++;
      $display("FAIL t6_period: got %b/%0d want 1/60",
               o_period_valid, o_period);
    end
    step(999);
    vecs++;
    if (o_stall !== 1'b0) begin
      errs++;
      $display("FAIL t6_stall_early: got %b want 0", o_stall);
    end
    step(1);
    vecs++;
    if ({o_stall, o_fault, o_sigma} !== 4'b1001) begin
      errs++;
      $display("FAIL t6_stall: got %b want 1001",
               {o_stall, o_fault, o_sigma});
    end
    i_RESET = 1'b1;
    step(1);
    i_RESET = 1'b0;
    vecs++;
    if ({o_sigma, o_counter, o_fault_code, o_period_valid, o_fault,
         o_stall, o_gate_enable} !== 10'b0) begin
      errs++;
      $display("FAIL t6_reset_flags: got %b want 0",
               {o_sigma, o_counter, o_fault_code, o_period_valid,
                o_fault, o_stall, o_gate_enable});
    end
    vecs++;
    if (o_period !== 32'd0) begin
      errs++;
      $display("FAIL t6_reset_period: got %0d want 0", o_period);
    end
  endtask

  initial begin
    test_reset;
    test_four_step;
    test_two_step;
    test_debounce;
    test_shoot_through;
    test_sequence_faults;
    test_stall_and_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
